// File: rtl/cp0_exc_pkg.sv
// CP0 shared definitions: register numbers, ExcCodes, field positions, vector.
package cp0_defs;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REGW     = 5;
  localparam int unsigned IPW      = 8;
  localparam int unsigned HWINTW   = 6;

  // Exception vector, shared with the PC generator
  localparam logic [XLEN-1:0] EXC_ADDR = 32'hbfc0_0380;

  // CP0 register numbers (sel 0)
  localparam logic [REGW-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REGW-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REGW-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REGW-1:0] CP0_STATUS   = 5'd12;
  localparam logic [REGW-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REGW-1:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Status bit positions
  localparam int unsigned ST_IE    = 0;
  localparam int unsigned ST_EXL   = 1;
  localparam int unsigned ST_IM_LO = 8;
  localparam int unsigned ST_IM_HI = 15;
  localparam int unsigned ST_BEV   = 22;

  // Cause bit positions
  localparam int unsigned CA_EXC_LO = 2;
  localparam int unsigned CA_EXC_HI = 6;
  localparam int unsigned CA_IP_LO  = 8;
  localparam int unsigned CA_IP_HI  = 15;
  localparam int unsigned CA_TI     = 30;
  localparam int unsigned CA_BD     = 31;

  // Implemented Status bits: BEV, IM, EXL, IE
  localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0040_ff03;

  // Cause register image as seen by mfc0
  typedef struct packed {
    logic           bd;
    logic           ti;
    logic [13:0]    zero_hi;
    logic [IPW-1:0] ip;
    logic           zero_mid;
    logic [4:0]     exc_code;
    logic [1:0]     zero_lo;
  } cause_t;

  // Address-error exceptions are the only ones that latch BadVAddr
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: half-rate Count, Compare match sets TI.
module cp0_timer
  import cp0_defs::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            count_we_i,
  input  logic            compare_we_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] count_o,
  output logic [XLEN-1:0] compare_o,
  output logic            ti_o
);

  logic            tick_q,    tick_d;
  logic [XLEN-1:0] count_q,   count_d;
  logic [XLEN-1:0] compare_q, compare_d;
  logic            ti_q,      ti_d;

  // Next-state: a Count write overrides the tick; a Compare write clears TI
  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    if (count_we_i) begin
      count_d = wdata_i;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      ti_d      = 1'b0;
    end else if (count_q == compare_q) begin
      ti_d      = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule

// File: rtl/cp0_exc.sv
// CP0 register file and commit-stage exception controller.
module cp0_exc
  import cp0_defs::*;
#(
  parameter logic [31:0] RST_STATUS = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [XLEN-1:0]   exc_pc,
  input  logic              exc_in_ds,
  input  logic [XLEN-1:0]   exc_badvaddr,
  input  logic              eret_in,
  input  logic              mtc0_we,
  input  logic [REGW-1:0]   cp0_waddr,
  input  logic [XLEN-1:0]   cp0_wdata,
  input  logic [REGW-1:0]   cp0_raddr,
  output logic [XLEN-1:0]   cp0_rdata,
  input  logic [HWINTW-1:0] hw_int,
  output logic              int_req,
  output logic              exc_oc,
  output logic              eret,
  output logic [XLEN-1:0]   epc
);

  logic [XLEN-1:0]   status_q,   status_d;
  logic [XLEN-1:0]   epc_q,      epc_d;
  logic [XLEN-1:0]   badvaddr_q, badvaddr_d;
  logic              bd_q,       bd_d;
  logic [4:0]        exccode_q,  exccode_d;
  logic [HWINTW-1:0] ip_hw_q,    ip_hw_d;
  logic [1:0]        ip_sw_q,    ip_sw_d;

  logic              mtc0_go;
  logic              count_we;
  logic              compare_we;
  logic [XLEN-1:0]   count;
  logic [XLEN-1:0]   compare;
  logic              ti;
  logic [IPW-1:0]    ip_all;
  cause_t            cause_c;

  // mtc0 only commits when neither an exception nor eret claims the cycle
  assign mtc0_go    = mtc0_we & ~exc_valid & ~eret_in;
  assign count_we   = mtc0_go & (cp0_waddr == CP0_COUNT);
  assign compare_we = mtc0_go & (cp0_waddr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .count_we_i   (count_we),
    .compare_we_i (compare_we),
    .wdata_i      (cp0_wdata),
    .count_o      (count),
    .compare_o    (compare),
    .ti_o         (ti)
  );

  // Next-state: exception > eret > mtc0; IP[15:10] resampled every cycle
  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = {hw_int[5] | ti, hw_int[4:0]};
    if (exc_valid) begin
      // A nested exception keeps the original EPC/BD
      if (!status_q[ST_EXL]) begin
        epc_d = exc_in_ds ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_in_ds;
      end
      status_d[ST_EXL] = 1'b1;
      exccode_d        = exc_code;
      if (is_addr_exc(exc_code)) begin
        badvaddr_d = exc_badvaddr;
      end
    end else if (eret_in) begin
      status_d[ST_EXL] = 1'b0;
    end else if (mtc0_we) begin
      case (cp0_waddr)
        CP0_STATUS: status_d = cp0_wdata & STATUS_WMASK;
        CP0_CAUSE:  ip_sw_d  = cp0_wdata[CA_IP_LO+1:CA_IP_LO];
        CP0_EPC:    epc_d    = cp0_wdata;
        default:    ;
      endcase
    end
  end

  // CP0 state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q   <= RST_STATUS & STATUS_WMASK;
      epc_q      <= '0;
      badvaddr_q <= '0;
      bd_q       <= 1'b0;
      exccode_q  <= '0;
      ip_hw_q    <= '0;
      ip_sw_q    <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      ip_hw_q    <= ip_hw_d;
      ip_sw_q    <= ip_sw_d;
    end
  end

  assign ip_all = {ip_hw_q, ip_sw_q};

  // Assemble the architectural Cause image
  always_comb begin
    cause_c          = '0;
    cause_c.bd       = bd_q;
    cause_c.ti       = ti;
    cause_c.ip       = ip_all;
    cause_c.exc_code = exccode_q;
  end

  // mfc0 read mux; unimplemented registers read zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_raddr)
      CP0_BADVADDR: cp0_rdata = badvaddr_q;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_q;
      CP0_CAUSE:    cp0_rdata = cause_c;
      CP0_EPC:      cp0_rdata = epc_q;
      default:      cp0_rdata = '0;
    endcase
  end

  assign int_req = status_q[ST_IE] & ~status_q[ST_EXL]
                 & (|(ip_all & status_q[ST_IM_HI:ST_IM_LO]));
  assign exc_oc  = exc_valid;
  assign eret    = eret_in & ~exc_valid;
  assign epc     = epc_q;

endmodule

// File: doc/cp0_exc.md
Name: cp0_exc

Overview:
- Coprocessor-0 register file and exception controller for the MIPS core.
- Sits at the commit (WB) stage.
- Accepts exception reports, `eret`, mtc0/mfc0 and hardware interrupt lines.
- Holds Status/Cause/EPC/BadVAddr/Count/Compare.
- Produces the `exc_oc`, `eret`, `epc` redirect signals consumed by the PC generator, plus an interrupt request back to the commit stage.

Parameters:
- EXC_ADDR, 32'hbfc00380: exception vector. Informational here; it is shared with the PC generator via the package.
- RST_STATUS, 32'h0040_0000: Status reset value (BEV=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- exc_valid  in  1  commit-stage instruction raises an exception this cycle.
- exc_code  in  5  ExcCode of the exception (0x00 Int, 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov).
- exc_pc  in  32  PC of the excepting instruction.
- exc_in_ds  in  1  excepting instruction is in a branch delay slot.
- exc_badvaddr  in  32  faulting address (used for AdEL/AdES only).
- eret_in  in  1  commit-stage instruction is `eret`.
- mtc0_we  in  1  mtc0 write enable.
- cp0_waddr  in  5  mtc0 destination register number (sel 0 only).
- cp0_wdata  in  32  mtc0 data.
- cp0_raddr  in  5  mfc0 source register number.
- cp0_rdata  out  32  mfc0 data; combinational.
- hw_int  in  6  external interrupt lines, level-sensitive.
- int_req  out  1  interrupt pending and enabled; combinational.
- exc_oc  out  1  redirect to exception vector.
- eret  out  1  redirect to EPC.
- epc  out  32  current EPC register value.

Behaviour:
Reset (reset=1, async):
- Status=RST_STATUS.
- Cause, EPC, BadVAddr, Count, Compare all 0.
- Count tick flop 0.
- Outputs: exc_oc=0, eret=0, epc=0, int_req=0.
- Reset asserted mid-operation discards all in-flight updates.

Register layout:
- Status: BEV[22], IM[15:8], EXL[1], IE[0] writable; all other bits read 0.
- Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[9:8] are mtc0-writable.

Redirect outputs:
- exc_oc = exc_valid, combinational. The PC generator samples it at the same edge.
- eret = eret_in & ~exc_valid.

Exception commit (edge with exc_valid=1):
- If Status.EXL==0:
  - EPC <= exc_in_ds ? exc_pc-4 : exc_pc
  - Cause.BD <= exc_in_ds
- If EXL==1: EPC and BD are unchanged (nested exception).
- Always:
  - Status.EXL <= 1
  - Cause.ExcCode <= exc_code
- BadVAddr <= exc_badvaddr only when exc_code is 0x04 or 0x05.

eret (edge with `eret`=1): Status.EXL <= 0. No other state changes.

Priority within one cycle: exc_valid > eret_in > mtc0_we.
- mtc0 is suppressed when exc_valid or eret_in is set.
- exc + eret together: only the exception takes effect.

mtc0 registers:
- 8 BadVAddr: read-only; write ignored.
- 9 Count: written value replaces the increment that cycle.
- 11 Compare: write also clears TI.
- 12 Status: writable bits as listed above.
- 13 Cause: IP[9:8] only.
- 14 EPC: full 32 bits.

Timer:
- Tick flop toggles every cycle; Count += 1 on cycles where tick==1 (half clock rate). Count wraps 0xffffffff -> 0.
- TI sets on the edge after Count==Compare.
- A Compare write in the same cycle wins: TI=0.

Interrupts:
- Cause.IP[15:10] <= {hw_int[5] | TI, hw_int[4:0]}, sampled every cycle.
- int_req = IE & ~EXL & |(IP & IM).

mfc0:
- cp0_rdata muxes the current register values.
- Unimplemented register numbers read 0.
- No bypass of a same-cycle mtc0.

Decomposition:
- Package cp0_defs holds:
  - CP0 register numbers (8, 9, 11, 12, 13, 14).
  - ExcCode constants.
  - Status/Cause bit-position constants.
  - EXC_ADDR, shared with the PC generator.
- One sub-module, cp0_timer, holds Count, Compare, the tick flop and TI set/clear. Its inputs are the write strobes and wdata; its outputs are count, compare and ti.

Test Plan:
- Reset: assert reset mid-count -> immediately Status=0x00400000, Cause=0, Count=0, exc_oc=0, eret=0, epc=0.
- Delay-slot exception: exc_valid, code 0x0c, exc_pc=0xbfc00100, exc_in_ds=1 -> exc_oc=1 that cycle; next cycle EPC=0xbfc000fc, Cause.BD=1, ExcCode=0x0c, EXL=1.
- Nested exception, then eret:
  - With EXL=1, a second exception (code 0x04, pc 0x80000020, badvaddr 0x80000003) -> EPC unchanged, BadVAddr=0x80000003, ExcCode=0x04.
  - Then eret_in -> eret=1, epc=old EPC, EXL=0.
- Timer: mtc0 Compare=10, Status=0x00008001 (IM7, IE) -> TI=1 and int_req=1 after Count reaches 10 (~20 cycles).
  - mtc0 Compare=100 -> TI=0, int_req=0.
- Simultaneous events: exc_valid + eret_in + mtc0 EPC=0x1234 -> exc_oc=1, eret=0, EPC not 0x1234, EXL=1.
- Interrupt gating: hw_int=6'b000001 with IM2=1, IE=1, EXL=0 -> int_req=1. Set EXL via an exception -> int_req=0.
